scpu_fetch_unit: RTL and testbench
==================================

Name: scpu_fetch_unit

Overview:
Instruction-fetch and PC stage directly upstream of the single-cycle control decoder. It holds the PC, fetches each instruction from instruction memory with a ready handshake, and presents the opcode fields (OPcode, Fun3, Fun7) to the decoder. When the datapath commits an instruction, it selects the next PC from the decoder's Jump/Branch/BranchN outputs and the ALU zero flag.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TIMEOUT, 16, maximum FETCH cycles without imem_ready before a bus error.
NOP_INST, 32'h0000_0013, instruction value held in inst while no fetched instruction is valid.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
imem_req  out  1  fetch request, high throughout FETCH
imem_addr  out  32  fetch address, equals pc
imem_ready  in  1  memory has valid data on imem_rdata this cycle
imem_rdata  in  32  fetched instruction word
inst  out  32  latched instruction
OPcode  out  5  inst[6:2]
Fun3  out  3  inst[14:12]
Fun7  out  1  inst[30]
inst_valid  out  1  inst is valid and awaiting commit
pc_out  out  32  PC of inst
pc_plus4  out  32  pc_out + 4, used for the JAL/JALR link value
commit  in  1  datapath finished inst; next-PC inputs are valid this cycle
Jump  in  2  00 none, 01 JAL, 10 JALR, 11 reserved
Branch  in  1  BEQ-type branch
BranchN  in  1  BNE-type branch
zero  in  1  ALU zero flag
imm  in  32  sign-extended immediate
rs1_data  in  32  register rs1 value, used by JALR
misalign  out  1  sticky flag: next-PC target not word aligned
bus_err  out  1  sticky flag: fetch timeout

Behaviour:
- Reset values: pc=RESET_PC, state=FETCH, inst=NOP_INST, inst_valid=0, misalign=0, bus_err=0, timeout counter=0.
- imem_req is combinational: 1 iff state==FETCH and rst==0.
- States: FETCH, EXEC, HALT.
- FETCH, imem_ready=1:
  - inst<=imem_rdata; inst_valid<=1; counter<=0; go to EXEC.
  - imem_ready may already be high in the first FETCH cycle. This gives zero-wait memory.
- FETCH, imem_ready=0:
  - counter increments.
  - When counter==TIMEOUT-1 with ready still low: bus_err<=1, go to HALT.
- commit is ignored in FETCH and HALT.
- EXEC:
  - inst, pc_out and inst_valid hold until commit=1.
  - On commit, compute next pc (rules below).
  - If the target is aligned: pc<=next, inst_valid<=0, inst<=NOP_INST, go to FETCH.
  - If misaligned: misalign<=1, pc unchanged, inst_valid<=0, go to HALT.
- Next-PC priority, all arithmetic 32-bit, wrapping modulo 2^32:
  - Jump==01: pc+imm.
  - Jump==10: (rs1_data+imm) & ~32'h1.
  - Else, if (Branch & zero) | (BranchN & ~zero): pc+imm.
  - Else: pc+4.
  - Jump==11 is treated as 00. Jump has priority over Branch/BranchN.
  - Branch and BranchN both high: the OR above applies, so the branch is always taken.
- Alignment check: target[1:0]!=2'b00 is misaligned. For JALR this reduces to bit 1, because bit 0 is already cleared.
- HALT: imem_req=0, outputs frozen, sticky flags held. Only rst leaves HALT.
- Throughput: minimum 2 cycles per instruction (1 FETCH + 1 EXEC with commit in the same cycle).
- rst mid-operation:
  - Synchronous reset has priority over every event on the same edge, including imem_ready or commit.
  - imem_req drops combinationally while rst is high.
  - A late imem_ready after reset is ignored unless state==FETCH.

Decomposition:
- Shared package scpu_pkg holds:
  - the Jump encodings JMP_NONE/JMP_JAL/JMP_JALR;
  - the state enum FETCH/EXEC/HALT;
  - the constant NOP_INST.
- One sub-module: scpu_next_pc. It is combinational and computes the target and misaligned flag from pc, imm, rs1_data, Jump, Branch, BranchN and zero.

Test Plan:
- Zero-wait sequential fetch:
  - Stimulus: rst for 2 cycles, then imem_ready always 1, rdata=0x00500093 at 0x0; commit one cycle after inst_valid; all jumps/branches off.
  - Response: OPcode=5'b00100, Fun3=000, Fun7=0; pc goes 0x0, 0x4, 0x8; exactly 2 cycles per instruction.
- Wait states and timeout:
  - Stimulus: imem_ready low for 3 cycles, then high.
  - Response: inst_valid rises on the cycle after ready; bus_err stays 0.
  - Stimulus: with TIMEOUT=16, ready never rises.
  - Response: bus_err=1 after 16 FETCH cycles; state HALT; imem_req=0.
- Branches at pc=0x100, imm=0xFFFFFFF8:
  - Branch=1, zero=1 -> pc=0xF8.
  - BranchN=1, zero=1 -> pc=0x104.
  - Branch=1, zero=0 -> pc=0x104.
  - BranchN=1, zero=0 -> pc=0xF8.
- Jumps:
  - JAL at pc=0x10, imm=0x20 -> pc=0x30.
  - JALR with rs1_data=0x1001, imm=0x3 -> pc=0x1004.
  - JALR with rs1_data=0x1001, imm=0x1 -> target 0x1002, misalign=1, state HALT, pc stays 0x10.
- Wrap-around: pc=0xFFFFFFFC, no jump/branch -> pc=0x00000000 with no error.
- Reset mid-operation:
  - Assert rst in the same cycle as commit -> pc=RESET_PC, inst=NOP_INST, inst_valid=0.
  - Assert rst while in HALT -> flags cleared; fetch resumes from RESET_PC.

Source files
------------

// File: rtl/scpu_pkg.sv
// Shared definitions for the single-cycle CPU front end: jump encodings,
// fetch-unit state encoding and the canonical NOP instruction.
package scpu_pkg;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_JAL  = 2'b01;
    localparam logic [1:0] JMP_JALR = 2'b10;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/scpu_next_pc.sv
// Combinational next-PC selection from the decoder's jump/branch controls
// and the ALU zero flag, plus the word-alignment check on the result.
module scpu_next_pc
    import scpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    input  logic [1:0]  jump,
    input  logic        branch,
    input  logic        branch_n,
    input  logic        zero,
    output logic [31:0] target,
    output logic        misaligned
);

    logic [31:0] pc_rel;
    logic [31:0] pc_seq;
    logic [31:0] jalr_sum;
    logic        br_taken;

    assign pc_rel   = pc + imm;
    assign pc_seq   = pc + 32'd4;
    assign jalr_sum = rs1_data + imm;
    // Both branch kinds high at once always resolves to taken.
    assign br_taken = (branch & zero) | (branch_n & ~zero);

    always_comb begin
        target = pc_seq;
        case (jump)
            JMP_JAL:  target = pc_rel;
            JMP_JALR: target = jalr_sum & ~32'h1;
            default:  target = br_taken ? pc_rel : pc_seq;
        endcase
    end

    assign misaligned = |target[1:0];

endmodule

// File: rtl/scpu_fetch_unit.sv
// PC register and instruction fetch with ready handshake and timeout;
// holds the fetched instruction for the decoder until the datapath commits.
module scpu_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] NOP_INST = scpu_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [4:0]  OPcode,
    output logic [2:0]  Fun3,
    output logic        Fun7,
    output logic        inst_valid,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    input  logic        commit,
    input  logic [1:0]  Jump,
    input  logic        Branch,
    input  logic        BranchN,
    input  logic        zero,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    output logic        misalign,
    output logic        bus_err
);

    import scpu_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        inst_q, inst_d;
    logic               inst_valid_q, inst_valid_d;
    logic               misalign_q, misalign_d;
    logic               bus_err_q, bus_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [31:0]        next_target;
    logic               next_misaligned;

    scpu_next_pc u_next_pc (
        .pc         (pc_q),
        .imm        (imm),
        .rs1_data   (rs1_data),
        .jump       (Jump),
        .branch     (Branch),
        .branch_n   (BranchN),
        .zero       (zero),
        .target     (next_target),
        .misaligned (next_misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    state_d = EXEC;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HALT;
                end
            end
            EXEC: begin
                if (commit) begin
                    state_d = next_misaligned ? HALT : FETCH;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        misalign_d   = misalign_q;
        bus_err_d    = bus_err_q;
        cnt_d        = cnt_q;
        case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    inst_d       = imem_rdata;
                    inst_valid_d = 1'b1;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        bus_err_d = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (commit) begin
                    inst_valid_d = 1'b0;
                    // A bad target freezes the PC at the faulting instruction.
                    if (next_misaligned) begin
                        misalign_d = 1'b1;
                    end else begin
                        pc_d   = next_target;
                        inst_d = NOP_INST;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            inst_q       <= NOP_INST;
            inst_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            misalign_q   <= misalign_d;
            bus_err_q    <= bus_err_d;
            cnt_q        <= cnt_d;
        end
    end

    // Request is gated by rst so it drops in the same cycle reset is raised.
    assign imem_req   = (state_q == FETCH) && !rst;
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign OPcode     = inst_q[6:2];
    assign Fun3       = inst_q[14:12];
    assign Fun7       = inst_q[30];
    assign inst_valid = inst_valid_q;
    assign pc_out     = pc_q;
    assign pc_plus4   = pc_q + 32'd4;
    assign misalign   = misalign_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_scpu_fetch_unit.sv
// Self-checking bench for scpu_fetch_unit: directed scenarios plus a
// randomized instruction stream checked against a transaction-level model.
module tb_scpu_fetch_unit;
    import scpu_pkg::*;

    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam int          TMO     = 16;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [4:0]  OPcode;
    logic [2:0]  Fun3;
    logic        Fun7;
    logic        inst_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        commit;
    logic [1:0]  Jump;
    logic        Branch;
    logic        BranchN;
    logic        zero;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic        misalign;
    logic        bus_err;

    int n_cmp = 0;
    int n_bad = 0;

    scpu_fetch_unit #(
        .RESET_PC (RST_PC),
        .TIMEOUT  (TMO),
        .NOP_INST (NOP_INST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .OPcode     (OPcode),
        .Fun3       (Fun3),
        .Fun7       (Fun7),
        .inst_valid (inst_valid),
        .pc_out     (pc_out),
        .pc_plus4   (pc_plus4),
        .commit     (commit),
        .Jump       (Jump),
        .Branch     (Branch),
        .BranchN    (BranchN),
        .zero       (zero),
        .imm        (imm),
        .rs1_data   (rs1_data),
        .misalign   (misalign),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Architectural next-PC rule, written straight from the ISA description.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [1:0] j,
                                             input logic b, input logic bn, input logic z,
                                             input logic [31:0] im, input logic [31:0] rs);
        if (j == 2'b01) return pc + im;
        if (j == 2'b10) return (rs + im) & 32'hFFFF_FFFE;
        if ((b && z) || (bn && !z)) return pc + im;
        return pc + 32'd4;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        commit     = 1'b0;
        Jump       = 2'b00;
        Branch     = 1'b0;
        BranchN    = 1'b0;
        zero       = 1'b0;
        imm        = 32'h0;
        rs1_data   = 32'h0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic fetch_word(input logic [31:0] w);
        imem_ready = 1'b1;
        imem_rdata = w;
        tick();
        imem_ready = 1'b0;
    endtask

    task automatic commit_op(input logic [1:0] j, input logic b, input logic bn, input logic z,
                             input logic [31:0] im, input logic [31:0] rs);
        commit   = 1'b1;
        Jump     = j;
        Branch   = b;
        BranchN  = bn;
        zero     = z;
        imm      = im;
        rs1_data = rs;
        tick();
        commit  = 1'b0;
        Jump    = 2'b00;
        Branch  = 1'b0;
        BranchN = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] nop;
        nop = NOP_INST;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
        n_cmp++; if (pc_out !== RST_PC) begin n_bad++; $display("FAIL rst_pc: got %h want %h", pc_out, RST_PC); end
        n_cmp++; if (imem_addr !== RST_PC) begin n_bad++; $display("FAIL rst_addr: got %h want %h", imem_addr, RST_PC); end
        n_cmp++; if (inst !== nop) begin n_bad++; $display("FAIL rst_inst: got %h want %h", inst, nop); end
        n_cmp++; if (OPcode !== nop[6:2]) begin n_bad++; $display("FAIL rst_opcode: got %b want %b", OPcode, nop[6:2]); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
        n_cmp++; if (misalign !== 1'b0 || bus_err !== 1'b0) begin n_bad++; $display("FAIL rst_flags: got %b%b want 00", misalign, bus_err); end
        n_cmp++; if (pc_plus4 !== RST_PC + 32'd4) begin n_bad++; $display("FAIL rst_pc4: got %h want %h", pc_plus4, RST_PC + 32'd4); end
        rst = 1'b0;
        #1;
        n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL req_after_rst: got %b want 1", imem_req); end
        rst = 1'b1;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL req_comb_rst: got %b want 0", imem_req); end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp_pc;
        int got, last;
        apply_reset();
        imem_ready = 1'b1;
        imem_rdata = 32'h0050_0093;
        exp_pc = RST_PC;
        got = 0;
        last = -1;
        for (int c = 0; c < 20 && got < 3; c++) begin
            tick();
            commit = 1'b0;
            if (inst_valid === 1'b1) begin
                n_cmp++; if (pc_out !== exp_pc) begin n_bad++; $display("FAIL zw_pc: got %h want %h", pc_out, exp_pc); end
                n_cmp++; if (OPcode !== 5'b00100 || Fun3 !== 3'b000 || Fun7 !== 1'b0)
                    begin n_bad++; $display("FAIL zw_fields: got %b/%b/%b want 00100/000/0", OPcode, Fun3, Fun7); end
                if (got > 0) begin
                    n_cmp++; if (c - last != 2) begin n_bad++; $display("FAIL zw_cpi: got %0d want 2", c - last); end
                end
                last = c;
                got++;
                exp_pc = exp_pc + 32'd4;
                commit = 1'b1;
            end
        end
        n_cmp++; if (got != 3) begin n_bad++; $display("FAIL zw_count: got %0d want 3", got); end
        imem_ready = 1'b0;
        tick();
        commit = 1'b0;
        n_cmp++; if (pc_out !== exp_pc) begin n_bad++; $display("FAIL zw_final_pc: got %h want %h", pc_out, exp_pc); end
    endtask

    task automatic test_wait_states();
        logic [31:0] exp_pc, w;
        int waits, hold, bad;
        apply_reset();
        exp_pc = RST_PC;
        for (int it = 0; it < 5; it++) begin
            waits = (it == 0) ? 3 : ((it == 1) ? TMO - 1 : $urandom_range(0, TMO - 1));
            bad = 0;
            for (int k = 0; k < waits; k++) begin
                commit = $urandom_range(0, 1);
                Jump   = 2'($urandom_range(0, 3));
                imm    = $urandom;
                tick();
                if (inst_valid !== 1'b0 || bus_err !== 1'b0 || imem_req !== 1'b1 || pc_out !== exp_pc) bad++;
            end
            commit = 1'b0;
            Jump   = 2'b00;
            n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL ws_wait[%0d]: got %0d bad cycles want 0", it, bad); end
            w = $urandom;
            fetch_word(w);
            n_cmp++; if (inst_valid !== 1'b1 || inst !== w) begin n_bad++; $display("FAIL ws_fetch[%0d]: got %b/%h want 1/%h", it, inst_valid, inst, w); end
            n_cmp++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL ws_buserr[%0d]: got %b want 0", it, bus_err); end
            hold = $urandom_range(0, 3);
            bad = 0;
            for (int k = 0; k < hold; k++) begin
                tick();
                if (inst_valid !== 1'b1 || inst !== w || pc_out !== exp_pc) bad++;
            end
            n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL ws_hold[%0d]: got %0d bad cycles want 0", it, bad); end
            commit_op(JMP_NONE, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            exp_pc = exp_pc + 32'd4;
            n_cmp++; if (inst_valid !== 1'b0 || inst !== NOP_INST || pc_out !== exp_pc)
                begin n_bad++; $display("FAIL ws_commit[%0d]: got %b/%h/%h want 0/%h/%h", it, inst_valid, inst, pc_out, NOP_INST, exp_pc); end
        end
    endtask

    task automatic test_timeout();
        int early;
        apply_reset();
        early = 0;
        for (int i = 1; i <= TMO; i++) begin
            tick();
            if (i < TMO && bus_err !== 1'b0) early++;
        end
        n_cmp++; if (early != 0) begin n_bad++; $display("FAIL to_early: got %0d early cycles want 0", early); end
        n_cmp++; if (bus_err !== 1'b1) begin n_bad++; $display("FAIL to_buserr: got %b want 1", bus_err); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL to_req: got %b want 0", imem_req); end
        imem_ready = 1'b1;
        imem_rdata = $urandom;
        tick();
        tick();
        imem_ready = 1'b0;
        n_cmp++; if (inst_valid !== 1'b0 || inst !== NOP_INST) begin n_bad++; $display("FAIL to_late_ready: got %b/%h want 0/%h", inst_valid, inst, NOP_INST); end
        commit_op(JMP_JAL, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
        n_cmp++; if (pc_out !== RST_PC || bus_err !== 1'b1 || misalign !== 1'b0)
            begin n_bad++; $display("FAIL to_frozen: got %h/%b/%b want %h/1/0", pc_out, bus_err, misalign, RST_PC); end
    endtask

    task automatic test_branches();
        logic [1:0]  tj  [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b10};
        logic        tb_ [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic        tbn [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        tz  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] texp[8] = '{32'hF8, 32'h104, 32'h104, 32'hF8, 32'hF8, 32'h104, 32'hF8, 32'h1FF8};
        for (int i = 0; i < 8; i++) begin
            apply_reset();
            fetch_word(NOP_INST);
            commit_op(JMP_JAL, 1'b0, 1'b0, 1'b0, 32'h100 - RST_PC, 32'h0);
            fetch_word($urandom);
            commit_op(tj[i], tb_[i], tbn[i], tz[i], 32'hFFFF_FFF8, 32'h2000);
            n_cmp++; if (pc_out !== texp[i] || misalign !== 1'b0)
                begin n_bad++; $display("FAIL br[%0d]: got %h/%b want %h/0", i, pc_out, misalign, texp[i]); end
        end
    endtask

    task automatic test_jumps();
        apply_reset();
        fetch_word(NOP_INST);
        commit_op(JMP_JAL, 1'b0, 1'b0, 1'b0, 32'h10 - RST_PC, 32'h0);
        n_cmp++; if (pc_out !== 32'h10) begin n_bad++; $display("FAIL jal_setup: got %h want 00000010", pc_out); end
        fetch_word(NOP_INST);
        commit_op(JMP_JAL, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        n_cmp++; if (pc_out !== 32'h30) begin n_bad++; $display("FAIL jal: got %h want 00000030", pc_out); end
        fetch_word(NOP_INST);
        commit_op(JMP_JALR, 1'b0, 1'b1, 1'b0, 32'h3, 32'h1001);
        n_cmp++; if (pc_out !== 32'h1004 || misalign !== 1'b0) begin n_bad++; $display("FAIL jalr: got %h/%b want 00001004/0", pc_out, misalign); end
        fetch_word(NOP_INST);
        commit_op(JMP_JAL, 1'b0, 1'b0, 1'b0, 32'h10 - 32'h1004, 32'h0);
        fetch_word(32'h0000_8067);
        commit_op(JMP_JALR, 1'b0, 1'b0, 1'b0, 32'h1, 32'h1001);
        n_cmp++; if (misalign !== 1'b1) begin n_bad++; $display("FAIL jalr_mis_flag: got %b want 1", misalign); end
        n_cmp++; if (pc_out !== 32'h10 || inst_valid !== 1'b0 || imem_req !== 1'b0)
            begin n_bad++; $display("FAIL jalr_mis_halt: got %h/%b/%b want 00000010/0/0", pc_out, inst_valid, imem_req); end
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        n_cmp++; if (inst_valid !== 1'b0 || misalign !== 1'b1) begin n_bad++; $display("FAIL halt_hold: got %b/%b want 0/1", inst_valid, misalign); end
    endtask

    task automatic test_reset_in_halt();
        logic [31:0] w;
        apply_reset();
        fetch_word(NOP_INST);
        commit_op(JMP_JAL, 1'b0, 1'b0, 1'b0, 32'h102, 32'h0);
        n_cmp++; if (misalign !== 1'b1) begin n_bad++; $display("FAIL jal_mis: got %b want 1", misalign); end
        rst = 1'b1;
        tick();
        n_cmp++; if (misalign !== 1'b0 || bus_err !== 1'b0 || pc_out !== RST_PC)
            begin n_bad++; $display("FAIL halt_rst: got %b/%b/%h want 0/0/%h", misalign, bus_err, pc_out, RST_PC); end
        rst = 1'b0;
        #1;
        n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL halt_rst_req: got %b want 1", imem_req); end
        w = $urandom;
        fetch_word(w);
        n_cmp++; if (inst_valid !== 1'b1 || inst !== w || pc_out !== RST_PC)
            begin n_bad++; $display("FAIL halt_resume: got %b/%h/%h want 1/%h/%h", inst_valid, inst, pc_out, w, RST_PC); end
    endtask

    task automatic test_wrap();
        apply_reset();
        fetch_word(NOP_INST);
        commit_op(JMP_JAL, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC - RST_PC, 32'h0);
        n_cmp++; if (pc_out !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0)
            begin n_bad++; $display("FAIL wrap_setup: got %h/%h want fffffffc/00000000", pc_out, pc_plus4); end
        fetch_word(NOP_INST);
        commit_op(JMP_NONE, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++; if (pc_out !== 32'h0 || misalign !== 1'b0 || bus_err !== 1'b0)
            begin n_bad++; $display("FAIL wrap: got %h/%b/%b want 00000000/0/0", pc_out, misalign, bus_err); end
    endtask

    task automatic test_reset_commit();
        apply_reset();
        fetch_word(NOP_INST);
        commit_op(JMP_JAL, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
        fetch_word($urandom);
        rst    = 1'b1;
        commit = 1'b1;
        Jump   = JMP_JAL;
        imm    = 32'h80;
        tick();
        commit = 1'b0;
        Jump   = JMP_NONE;
        n_cmp++; if (pc_out !== RST_PC || inst !== NOP_INST || inst_valid !== 1'b0)
            begin n_bad++; $display("FAIL rst_commit: got %h/%h/%b want %h/%h/0", pc_out, inst, inst_valid, RST_PC, NOP_INST); end
        imem_ready = 1'b1;
        imem_rdata = $urandom;
        tick();
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", inst_valid); end
        rst = 1'b0;
        imem_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, w, im, rs, t;
        logic [1:0]  j;
        logic        b, bn, z, mis;
        int waits, hold, bad;
        apply_reset();
        exp_pc = RST_PC;
        for (int n = 0; n < 80; n++) begin
            waits = $urandom_range(0, 4);
            bad = 0;
            for (int k = 0; k < waits; k++) begin
                commit = $urandom_range(0, 1);
                tick();
                if (inst_valid !== 1'b0 || pc_out !== exp_pc || imem_addr !== exp_pc) bad++;
            end
            commit = 1'b0;
            n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL rnd_wait[%0d]: got %0d bad cycles want 0", n, bad); end
            w = $urandom;
            fetch_word(w);
            n_cmp++; if (inst !== w || OPcode !== w[6:2] || Fun3 !== w[14:12] || Fun7 !== w[30])
                begin n_bad++; $display("FAIL rnd_inst[%0d]: got %h/%b/%b/%b want %h", n, inst, OPcode, Fun3, Fun7, w); end
            n_cmp++; if (pc_out !== exp_pc || pc_plus4 !== exp_pc + 32'd4 || inst_valid !== 1'b1)
                begin n_bad++; $display("FAIL rnd_pc[%0d]: got %h/%h/%b want %h/%h/1", n, pc_out, pc_plus4, inst_valid, exp_pc, exp_pc + 32'd4); end
            hold = $urandom_range(0, 2);
            for (int k = 0; k < hold; k++) tick();
            j  = 2'($urandom_range(0, 3));
            b  = 1'($urandom_range(0, 1));
            bn = 1'($urandom_range(0, 1));
            z  = 1'($urandom_range(0, 1));
            im = $urandom;
            if ($urandom_range(0, 7) != 0) im = im & 32'hFFFF_FFFC;
            rs = $urandom;
            if ($urandom_range(0, 7) != 0) rs = rs & 32'hFFFF_FFFC;
            t   = ref_next(exp_pc, j, b, bn, z, im, rs);
            mis = (t[1:0] != 2'b00);
            commit_op(j, b, bn, z, im, rs);
            if (mis) begin
                n_cmp++; if (misalign !== 1'b1 || pc_out !== exp_pc || imem_req !== 1'b0)
                    begin n_bad++; $display("FAIL rnd_mis[%0d]: got %b/%h/%b want 1/%h/0", n, misalign, pc_out, imem_req, exp_pc); end
                apply_reset();
                exp_pc = RST_PC;
            end else begin
                n_cmp++; if (misalign !== 1'b0 || pc_out !== t)
                    begin n_bad++; $display("FAIL rnd_next[%0d]: got %b/%h want 0/%h", n, misalign, pc_out, t); end
                exp_pc = t;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_timeout();
        test_branches();
        test_jumps();
        test_reset_in_halt();
        test_wrap();
        test_reset_commit();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
